// File: rtl/fsm_mealy.sv
// fsm_mealy: serial bit-sequence detector built as a Mealy FSM.
// The state counts how many leading pattern bits have been matched so far.
// o_data_out rises combinationally in the cycle the final pattern bit is present.
// The transition table is derived from PATTERN when the design is elaborated.
module fsm_mealy #(
  parameter int                  PAT_LEN = 3,
  parameter logic [PAT_LEN-1:0]  PATTERN = 3'b101,
  parameter bit                  OVERLAP = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_data_in,
  output logic o_data_out
);

  // Binary state encoding that is wide enough for states 0..PAT_LEN-1.
  localparam int STATE_W = (PAT_LEN <= 2) ? 1 : $clog2(PAT_LEN);
  localparam int NUM_ENC = 1 << STATE_W;

  typedef logic [STATE_W-1:0] stateT;

  localparam stateT S0         = stateT'(0);
  localparam stateT LAST_STATE = stateT'(PAT_LEN - 1);

  // Returns the pattern bit at position idx in arrival order.
  // Position 0 is the first bit received, which is the MSB of PATTERN.
  function automatic bit patBit(input int idx);
    return PATTERN[PAT_LEN-1-idx];
  endfunction

  // Returns the longest k < PAT_LEN for which the last k bits of the stream equal
  // the first k pattern bits. The stream is the current prefix of length s
  // followed by bit b.
  function automatic int fallbackState(input int s, input bit b);
    logic [16:0] seq;
    int          len;
    int          kMax;
    int          result;
    bit          found;
    bit          ok;
    seq    = '0;
    result = 0;
    found  = 1'b0;
    for (int i = 0; i < s; i++) begin
      seq[i] = patBit(i);
    end
    seq[s] = b;
    len    = s + 1;
    kMax   = (len < PAT_LEN) ? len : PAT_LEN - 1;
    for (int k = kMax; k > 0; k--) begin
      if (!found) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (seq[len-k+j] != patBit(j)) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          result = k;
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

  // Returns the length of the longest proper prefix of PATTERN that is also a suffix
  // of PATTERN. After a completed match, this length is the state to resume from
  // when overlapping matches are allowed.
  function automatic int borderState();
    int  result;
    bit  found;
    bit  ok;
    result = 0;
    found  = 1'b0;
    for (int k = PAT_LEN - 1; k > 0; k--) begin
      if (!found) begin
        ok = 1'b1;
        for (int j = 0; j < k; j++) begin
          if (patBit(PAT_LEN-k+j) != patBit(j)) begin
            ok = 1'b0;
          end
        end
        if (ok) begin
          result = k;
          found  = 1'b1;
        end
      end
    end
    return result;
  endfunction

  // Computes the full next-state rule for a given state and input bit.
  // Encodings at or above PAT_LEN are unreachable, so they collapse to S0.
  function automatic int nextState(input int s, input bit b);
    int result;
    if (s >= PAT_LEN) begin
      result = 0;
    end else if ((s == PAT_LEN - 1) && (b == PATTERN[0])) begin
      result = OVERLAP ? borderState() : 0;
    end else begin
      result = fallbackState(s, b);
    end
    return result;
  endfunction

  stateT nextOnZero [NUM_ENC];
  stateT nextOnOne  [NUM_ENC];

  // Elaboration-time transition table, with one entry per encoding and input bit.
  for (genvar s = 0; s < NUM_ENC; s++) begin : gTable
    localparam int N0 = nextState(s, 1'b0);
    localparam int N1 = nextState(s, 1'b1);
    assign nextOnZero[s] = stateT'(N0);
    assign nextOnOne[s]  = stateT'(N1);
  end

  stateT stateQ;
  stateT stateD;
  logic  dataBit;

  // Cleans up the input bit. An unknown or X input takes the else path and reads
  // as a 0, so it never reaches the state register.
  always_comb begin
    dataBit = 1'b0;
    if (i_data_in) begin
      dataBit = 1'b1;
    end
  end

  // Looks up the next state from the precomputed table.
  always_comb begin
    stateD = S0;
    if (dataBit) begin
      stateD = nextOnOne[stateQ];
    end else begin
      stateD = nextOnZero[stateQ];
    end
  end

  // State register. Reset is asynchronous and discards any partial match.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      stateQ <= S0;
    end else begin
      stateQ <= stateD;
    end
  end

  // Mealy flag. It is only valid from the last pattern state while reset is released.
  assign o_data_out = i_reset && (stateQ == LAST_STATE) && (dataBit == PATTERN[0]);

endmodule

// File: tb/tb_fsm_mealy.sv
// tb_fsm_mealy: checks both overlap modes of the 101 detector against a model of
// the received history.
module tb_fsm_mealy;

  localparam int           PAT_LEN = 3;
  localparam logic [2:0]   PATTERN = 3'b101;

  logic clock;
  logic resetN;
  logic dataIn;
  logic outOv;
  logic outNo;

  int assertCount = 0;
  int failCount   = 0;

  bit histOv[$];
  bit histNo[$];

  fsm_mealy #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .OVERLAP(1'b1)) dutOv (
    .i_clock   (clock),
    .i_reset   (resetN),
    .i_data_in (dataIn),
    .o_data_out(outOv)
  );

  fsm_mealy #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .OVERLAP(1'b0)) dutNo (
    .i_clock   (clock),
    .i_reset   (resetN),
    .i_data_in (dataIn),
    .o_data_out(outNo)
  );

  // Generates a free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compares one observed value with its expected value and reports a mismatch.
  task automatic checkOutput(input string tag, input logic got, input logic exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
    end
  endtask

  // Reports whether the last PAT_LEN bits of a history equal the pattern.
  function automatic bit tailMatches(input bit hist[$]);
    int n;
    n = hist.size();
    if (n < PAT_LEN) return 1'b0;
    for (int j = 0; j < PAT_LEN; j++) begin
      if (hist[n-PAT_LEN+j] != PATTERN[PAT_LEN-1-j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Feeds one consumed bit into the model.
  // The non-overlapping history restarts empty after each match.
  task automatic modelPush(input bit b, output bit expOv, output bit expNo);
    histOv.push_back(b);
    histNo.push_back(b);
    expOv = tailMatches(histOv);
    expNo = tailMatches(histNo);
    if (expNo) histNo.delete();
    while (histOv.size() > PAT_LEN) void'(histOv.pop_front());
    while (histNo.size() > PAT_LEN) void'(histNo.pop_front());
  endtask

  // Clears both model histories, as a reset does in the design.
  task automatic modelReset();
    histOv.delete();
    histNo.delete();
  endtask

  // Drives one bit from a falling edge, checks both flags, and lets the next rising edge consume the bit.
  task automatic applyStimulus(input bit b, input string tag);
    bit expOv;
    bit expNo;
    dataIn = b;
    modelPush(b, expOv, expNo);
    #1;
    checkOutput({tag, "/ov"}, outOv, expOv);
    checkOutput({tag, "/no"}, outNo, expNo);
    @(negedge clock);
  endtask

  // Asserts reset asynchronously in the middle of a low phase and holds it across one rising edge.
  task automatic midCycleReset();
    #2 resetN = 1'b0;
    modelReset();
    #1;
    checkOutput("asyncRst/ov", outOv, 1'b0);
    checkOutput("asyncRst/no", outNo, 1'b0);
    @(negedge clock);
    resetN = 1'b1;
  endtask

  initial begin
    bit seqA[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit seqB[7] = '{1, 0, 1, 0, 1, 0, 1};
    bit seqC[5] = '{1, 1, 1, 0, 1};
    bit expOv;
    bit expNo;

    resetN = 1'b0;
    dataIn = 1'b0;
    @(negedge clock);

    // Holds reset for 10 clocks while the input toggles, so both flags must stay low.
    for (int i = 0; i < 10; i++) begin
      dataIn = (i % 2 == 0);
      #1;
      checkOutput("inReset/ov", outOv, 1'b0);
      checkOutput("inReset/no", outNo, 1'b0);
      @(negedge clock);
    end
    resetN = 1'b1;
    modelReset();

    // Drives the 10100101 sequence.
    foreach (seqA[i]) applyStimulus(seqA[i], "seqA");

    // Drives the alternating 1010101 sequence from a clean state.
    midCycleReset();
    foreach (seqB[i]) applyStimulus(seqB[i], "seqB");

    // Drives 11101, which exercises the S1 self-loop.
    midCycleReset();
    foreach (seqC[i]) applyStimulus(seqC[i], "seqC");

    // Drives 1,0, then applies an async reset, then drives 1, 0, 1.
    // The final 1 detects only if the state after the first 1 was S1.
    midCycleReset();
    applyStimulus(1'b1, "rstSeq");
    applyStimulus(1'b0, "rstSeq");
    midCycleReset();
    applyStimulus(1'b1, "rstSeq");
    applyStimulus(1'b0, "rstSeq");
    applyStimulus(1'b1, "rstSeq");

    // Toggles the input within the detect cycle.
    // The flag must follow the input, and the 0 that is consumed sends the FSM to S0.
    midCycleReset();
    applyStimulus(1'b1, "toggle");
    applyStimulus(1'b0, "toggle");
    dataIn = 1'b1;
    #1;
    checkOutput("toggleHi/ov", outOv, 1'b1);
    checkOutput("toggleHi/no", outNo, 1'b1);
    dataIn = 1'b0;
    #1;
    checkOutput("toggleLo/ov", outOv, 1'b0);
    checkOutput("toggleLo/no", outNo, 1'b0);
    modelPush(1'b0, expOv, expNo);
    @(negedge clock);
    applyStimulus(1'b1, "afterToggle");
    applyStimulus(1'b0, "afterToggle");
    applyStimulus(1'b1, "afterToggle");

    // Applies random bits, with an occasional async reset mixed in.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) midCycleReset();
      applyStimulus(1'($urandom_range(0, 1)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
